// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss fill controller: block geometry,
// FSM state encoding and block/word address helpers.
package cache_fill_fsm_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int MEM_LATENCY     = 4;
    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;
    localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W           = WORD_IDX_W + 1;

    // Byte-offset bits inside one block (0x000F for eight 16-bit words)
    localparam logic [ADDR_W-1:0] BLOCK_OFFSET_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

    typedef enum logic {
        FSM_IDLE = 1'b0,
        FSM_FILL = 1'b1
    } fill_state_e;

    // Align a byte address down to the start of its block
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return addr & ~BLOCK_OFFSET_MASK;
    endfunction

    // Byte address of word idx in the block; only offset bits are touched,
    // so the result can never leave the block
    function automatic logic [ADDR_W-1:0] word_address(input logic [ADDR_W-1:0]     base,
                                                       input logic [WORD_IDX_W-1:0] idx);
        return base | ADDR_W'({idx, 1'b0});
    endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bus between the fill controller, the cache arrays and main memory.
// master = fill controller side, slave = cache/memory side.
interface cache_fill_fsm_if;
    import cache_fill_fsm_pkg::*;

    logic                  miss_detected;
    logic [ADDR_W-1:0]     miss_address;
    logic [DATA_W-1:0]     memory_data;
    logic                  memory_data_valid;
    logic                  fsm_busy;
    logic                  memory_read_en;
    logic [ADDR_W-1:0]     memory_address;
    logic                  write_data_array;
    logic [WORD_IDX_W-1:0] cache_word_offset;
    logic [DATA_W-1:0]     fill_data;
    logic                  write_tag_array;

    modport master (
        input  miss_detected, miss_address, memory_data, memory_data_valid,
        output fsm_busy, memory_read_en, memory_address, write_data_array,
               cache_word_offset, fill_data, write_tag_array
    );

    modport slave (
        output miss_detected, miss_address, memory_data, memory_data_valid,
        input  fsm_busy, memory_read_en, memory_address, write_data_array,
               cache_word_offset, fill_data, write_tag_array
    );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// Up-counter with synchronous clear and count enable, used to track
// issued reads and received words during a block fill.
module fill_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Clear wins over enable so a new fill always starts counting from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: on a miss, streams one block from main memory
// one word per read, writes each returned word into the data array and
// pulses the tag write with the final word. Pipeline stalls on fsm_busy.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    cache_fill_fsm_if.master bus
);

    fill_state_e       r_state;
    fill_state_e       w_next_state;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  w_issue_cnt;
    logic [CNT_W-1:0]  w_recv_cnt;
    logic              w_clear;
    logic              w_issue;
    logic              w_recv;

    fill_counter #(.WIDTH(CNT_W)) u_issue_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_enable (w_issue),
        .o_count  (w_issue_cnt)
    );

    fill_counter #(.WIDTH(CNT_W)) u_recv_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_enable (w_recv),
        .o_count  (w_recv_cnt)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FSM_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the block base only when a fill starts; later address changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base <= '0;
        end else if ((r_state == FSM_IDLE) && bus.miss_detected) begin
            r_base <= block_base(bus.miss_address);
        end
    end

    // Next-state and output decode; reads and returned words are tracked independently
    always_comb begin
        w_next_state          = r_state;
        w_clear               = 1'b0;
        w_issue               = 1'b0;
        w_recv                = 1'b0;
        bus.fsm_busy          = 1'b0;
        bus.memory_read_en    = 1'b0;
        bus.memory_address    = '0;
        bus.write_data_array  = 1'b0;
        bus.cache_word_offset = '0;
        bus.fill_data         = '0;
        bus.write_tag_array   = 1'b0;

        case (r_state)
            FSM_IDLE: begin
                bus.fsm_busy = bus.miss_detected;
                if (bus.miss_detected) begin
                    w_clear      = 1'b1;
                    w_next_state = FSM_FILL;
                end
            end
            FSM_FILL: begin
                bus.fsm_busy       = 1'b1;
                w_issue            = (w_issue_cnt < CNT_W'(WORDS_PER_BLOCK));
                bus.memory_read_en = w_issue;
                bus.memory_address = word_address(r_base, w_issue_cnt[WORD_IDX_W-1:0]);
                if (bus.memory_data_valid) begin
                    w_recv                = 1'b1;
                    bus.write_data_array  = 1'b1;
                    bus.cache_word_offset = w_recv_cnt[WORD_IDX_W-1:0];
                    bus.fill_data         = bus.memory_data;
                    if (w_recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) begin
                        bus.write_tag_array = 1'b1;
                        w_next_state        = FSM_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = FSM_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm. A fixed-latency memory model
// answers the controller's reads; expected outputs come from a per-fill
// timeline computed from the miss cycle and block base.
module tb_cache_fill_fsm;
    import cache_fill_fsm_pkg::*;

    typedef struct packed {
        logic                  busy;
        logic                  rd;
        logic [15:0]           addr;
        logic                  wd;
        logic [WORD_IDX_W-1:0] off;
        logic [15:0]           fd;
        logic                  wt;
    } outs_t;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } rd_t;

    localparam int LAST_K = WORDS_PER_BLOCK + MEM_LATENCY;

    logic clk;
    logic rst;

    cache_fill_fsm_if bus();

    cache_fill_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checkCount = 0;
    int          passCount  = 0;
    int          cycleNum   = 0;
    logic        missIn     = 1'b0;
    logic [15:0] addrIn     = 16'h0;
    logic        strayValid = 1'b0;
    logic [15:0] memSalt    = 16'h0;
    rd_t         readQ[$];
    outs_t       obsRaw;
    outs_t       obsN;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: address-dependent pattern with a random per-run salt
    function automatic logic [15:0] memWord(input logic [15:0] a);
        return (a * 16'h9E37) ^ memSalt;
    endfunction

    function automatic logic [15:0] baseOf(input logic [15:0] a);
        return a & ~16'(2 * WORDS_PER_BLOCK - 1);
    endfunction

    // Expected outputs in cycle c for a fill whose miss was seen in cycle m
    function automatic outs_t expFill(input int c, input int m, input logic [15:0] base);
        outs_t e;
        int    k;
        e = '0;
        k = c - m;
        if (k >= 0 && k <= LAST_K) e.busy = 1'b1;
        if (k >= 1 && k <= WORDS_PER_BLOCK) begin
            e.rd   = 1'b1;
            e.addr = base + 16'(2 * (k - 1));
        end
        if (k >= 1 + MEM_LATENCY && k <= LAST_K) begin
            e.wd  = 1'b1;
            e.off = WORD_IDX_W'(k - 1 - MEM_LATENCY);
            e.fd  = memWord(base + 16'(2 * (k - 1 - MEM_LATENCY)));
        end
        if (k == LAST_K) e.wt = 1'b1;
        return e;
    endfunction

    function automatic string fmt(input outs_t o);
        return $sformatf("busy=%b rd=%b addr=%h wr=%b off=%0d data=%h tag=%b",
                         o.busy, o.rd, o.addr, o.wd, o.off, o.fd, o.wt);
    endfunction

    function automatic outs_t sampleOutputs();
        outs_t o;
        o.busy = bus.fsm_busy;
        o.rd   = bus.memory_read_en;
        o.addr = bus.memory_address;
        o.wd   = bus.write_data_array;
        o.off  = bus.cache_word_offset;
        o.fd   = bus.fill_data;
        o.wt   = bus.write_tag_array;
        return o;
    endfunction

    // One cycle: drive inputs at the falling edge, let memory answer due reads,
    // sample outputs just after, and record any newly issued read
    task automatic tick();
        @(negedge clk);
        cycleNum++;
        bus.miss_detected     = missIn;
        bus.miss_address      = addrIn;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = 16'($urandom);
        while (readQ.size() > 0 && readQ[0].due < cycleNum) void'(readQ.pop_front());
        if (readQ.size() > 0 && readQ[0].due == cycleNum) begin
            bus.memory_data_valid = 1'b1;
            bus.memory_data       = memWord(readQ[0].addr);
            void'(readQ.pop_front());
        end else if (strayValid) begin
            bus.memory_data_valid = 1'b1;
        end
        #1;
        obsRaw = sampleOutputs();
        obsN   = obsRaw;
        if (!obsN.rd) obsN.addr = '0;
        if (!obsN.wd) begin
            obsN.off = '0;
            obsN.fd  = '0;
        end
        if (bus.memory_read_en) readQ.push_back('{cycleNum + MEM_LATENCY, bus.memory_address});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        missIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rst = 1'b0;
            tick();
            checkCount++;
            if (obsRaw !== outs_t'(0))
                $display("[TB] FAIL reset_state cyc %0d: got %s, want all zero", i, fmt(obsRaw));
            else passCount++;
        end
    endtask

    task automatic test_basic_fill();
        int m;
        addrIn = 16'h1236;
        m = cycleNum + 1;
        for (int k = 0; k <= LAST_K + 1; k++) begin
            missIn = (k <= LAST_K);
            tick();
            checkCount++;
            if (obsN !== expFill(cycleNum, m, 16'h1230))
                $display("[TB] FAIL basic_fill k=%0d: got %s, want %s", k, fmt(obsN),
                         fmt(expFill(cycleNum, m, 16'h1230)));
            else passCount++;
        end
        missIn = 1'b0;
    endtask

    task automatic test_wrap();
        int m;
        int outside;
        int tags;
        outside = 0;
        tags = 0;
        addrIn = 16'hFFFF;
        m = cycleNum + 1;
        for (int k = 0; k <= LAST_K + 1; k++) begin
            missIn = (k <= LAST_K);
            tick();
            if (obsRaw.rd && (obsRaw.addr & 16'hFFF0) != 16'hFFF0) outside++;
            if (obsRaw.wt) tags++;
            checkCount++;
            if (obsN !== expFill(cycleNum, m, 16'hFFF0))
                $display("[TB] FAIL wrap_fill k=%0d: got %s, want %s", k, fmt(obsN),
                         fmt(expFill(cycleNum, m, 16'hFFF0)));
            else passCount++;
        end
        missIn = 1'b0;
        checkCount++;
        if (outside != 0) $display("[TB] FAIL wrap_outside_reads: got %0d, want 0", outside);
        else passCount++;
        checkCount++;
        if (tags != 1) $display("[TB] FAIL wrap_tag_count: got %0d, want 1", tags);
        else passCount++;
    endtask

    task automatic test_idle_valid();
        missIn = 1'b0;
        strayValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkCount++;
            if (obsRaw !== outs_t'(0))
                $display("[TB] FAIL idle_valid i=%0d: got %s, want all zero", i, fmt(obsRaw));
            else passCount++;
        end
        strayValid = 1'b0;
    endtask

    task automatic test_addr_change();
        int m;
        int tags;
        tags = 0;
        addrIn = 16'h1230;
        m = cycleNum + 1;
        for (int k = 0; k <= LAST_K + 1; k++) begin
            missIn = (k <= LAST_K);
            if (k == 3) addrIn = 16'h4000;
            tick();
            if (obsRaw.wt) tags++;
            checkCount++;
            if (obsN !== expFill(cycleNum, m, 16'h1230))
                $display("[TB] FAIL addr_change k=%0d: got %s, want %s", k, fmt(obsN),
                         fmt(expFill(cycleNum, m, 16'h1230)));
            else passCount++;
        end
        missIn = 1'b0;
        checkCount++;
        if (tags != 1) $display("[TB] FAIL addr_change_tags: got %0d, want 1", tags);
        else passCount++;
    endtask

    task automatic test_reset_mid_fill();
        int m;
        addrIn = 16'h5A5A;
        m = cycleNum + 1;
        for (int k = 0; k <= 6; k++) begin
            missIn = 1'b1;
            tick();
            checkCount++;
            if (obsN !== expFill(cycleNum, m, 16'h5A50))
                $display("[TB] FAIL pre_reset k=%0d: got %s, want %s", k, fmt(obsN),
                         fmt(expFill(cycleNum, m, 16'h5A50)));
            else passCount++;
        end
        rst = 1'b1;
        missIn = 1'b0;
        bus.miss_detected = 1'b0;
        bus.memory_data_valid = 1'b0;
        readQ.delete();
        #1;
        obsRaw = sampleOutputs();
        checkCount++;
        if (obsRaw !== outs_t'(0))
            $display("[TB] FAIL reset_immediate: got %s, want all zero", fmt(obsRaw));
        else passCount++;
        tick();
        checkCount++;
        if (obsRaw !== outs_t'(0))
            $display("[TB] FAIL reset_held: got %s, want all zero", fmt(obsRaw));
        else passCount++;
        rst = 1'b0;
        addrIn = 16'h0020;
        m = cycleNum + 1;
        for (int k = 0; k <= LAST_K + 1; k++) begin
            missIn = (k <= LAST_K);
            tick();
            checkCount++;
            if (obsN !== expFill(cycleNum, m, 16'h0020))
                $display("[TB] FAIL post_reset_fill k=%0d: got %s, want %s", k, fmt(obsN),
                         fmt(expFill(cycleNum, m, 16'h0020)));
            else passCount++;
        end
        missIn = 1'b0;
    endtask

    task automatic test_back_to_back();
        int    m1;
        int    m2;
        outs_t e;
        m1 = cycleNum + 1;
        m2 = m1 + LAST_K + 1;
        for (int k = 0; k <= 2 * LAST_K + 2; k++) begin
            missIn = (k <= 2 * LAST_K + 1);
            addrIn = (k <= LAST_K) ? 16'h3332 : 16'h7778;
            tick();
            e = outs_t'(expFill(cycleNum, m1, 16'h3330) | expFill(cycleNum, m2, 16'h7770));
            checkCount++;
            if (obsN !== e)
                $display("[TB] FAIL back_to_back k=%0d: got %s, want %s", k, fmt(obsN), fmt(e));
            else passCount++;
        end
        missIn = 1'b0;
    endtask

    task automatic test_random();
        int          m;
        int          mNew;
        int          gap;
        int          chg;
        logic [15:0] base;
        logic [15:0] baseNew;
        logic [15:0] a;
        outs_t       e;
        m = -1000;
        base = '0;
        for (int f = 0; f < 8; f++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                missIn = 1'b0;
                strayValid = 1'($urandom_range(0, 1));
                tick();
                e = expFill(cycleNum, m, base);
                checkCount++;
                if (obsN !== e)
                    $display("[TB] FAIL rand_gap f=%0d g=%0d: got %s, want %s", f, g, fmt(obsN), fmt(e));
                else passCount++;
            end
            strayValid = 1'b0;
            a = 16'($urandom);
            baseNew = baseOf(a);
            mNew = cycleNum + 1;
            chg = $urandom_range(1, LAST_K + 4);
            addrIn = a;
            for (int k = 0; k <= LAST_K; k++) begin
                missIn = 1'b1;
                if (k == chg) addrIn = 16'($urandom);
                tick();
                e = outs_t'(expFill(cycleNum, m, base) | expFill(cycleNum, mNew, baseNew));
                checkCount++;
                if (obsN !== e)
                    $display("[TB] FAIL rand_fill f=%0d k=%0d: got %s, want %s", f, k, fmt(obsN), fmt(e));
                else passCount++;
            end
            m = mNew;
            base = baseNew;
        end
        missIn = 1'b0;
        tick();
        checkCount++;
        if (obsRaw !== outs_t'(0))
            $display("[TB] FAIL rand_final: got %s, want all zero", fmt(obsRaw));
        else passCount++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        memSalt = 16'($urandom);
        rst = 1'b1;
        bus.miss_detected = 1'b0;
        bus.miss_address = 16'h0;
        bus.memory_data = 16'h0;
        bus.memory_data_valid = 1'b0;
        test_reset();
        test_basic_fill();
        test_wrap();
        test_idle_valid();
        test_addr_change();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
